// File: rtl/tl_error_slave.sv
// tl_error_slave: TileLink-UH sink that answers every request with a denied response.
// A-channel requests are queued as {opcode, size, source}. Each queue entry is replayed
// on the D channel as the matching ack type, with d_denied set.
// Optional feature: define TL_ERROR_SLAVE_COUNT_EN to build a saturating counter of
// denied responses on err_count. Without it, err_count is tied to zero.
module tl_error_slave #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SRC_W  = 4,
  parameter int unsigned SIZE_W = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [SIZE_W-1:0]   a_size,
  input  logic [SRC_W-1:0]    a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_mask,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                a_corrupt,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [SIZE_W-1:0]   d_size,
  output logic [SRC_W-1:0]    d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic [DATA_W-1:0]   d_data,
  output logic [15:0]         err_count
);

  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW     = $clog2(DEPTH + 1);
  localparam int unsigned BeatW    = 2 ** SIZE_W;
  localparam int unsigned BusBytes = DATA_W / 8;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] Full    = CntW'(DEPTH);

  // Number of bus beats for a transfer of 2^sz bytes, minus one.
  function automatic logic [BeatW-1:0] beats_m1(input logic [SIZE_W-1:0] sz);
    int unsigned bytes;
    bytes = 32'd1 << sz;
    if (bytes <= BusBytes) return '0;
    return BeatW'(bytes / BusBytes - 1);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  logic [2:0]        ent_op_q   [DEPTH];
  logic [SIZE_W-1:0] ent_size_q [DEPTH];
  logic [SRC_W-1:0]  ent_src_q  [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [BeatW-1:0] a_beat_q, a_beat_d, d_beat_q, d_beat_d;
  logic             a_ready_q, a_ready_d;
  logic             a_fire, enq, d_fire, d_last, deq;
  logic [2:0]        head_op;
  logic [SIZE_W-1:0] head_size;
  logic [SRC_W-1:0]  head_src;
  logic              head_data;

  assign a_ready   = a_ready_q;
  assign d_valid   = (count_q != '0);
  assign head_op   = ent_op_q[rd_ptr_q];
  assign head_size = ent_size_q[rd_ptr_q];
  assign head_src  = ent_src_q[rd_ptr_q];
  // Arithmetic, Logical and Get return data beats (marked corrupt since the data is bogus).
  assign head_data = (head_op == 3'd2) || (head_op == 3'd3) || (head_op == 3'd4);

  // Address, param and write payload play no part in a denied response.
  logic unused_inputs;
  assign unused_inputs = ^{a_param, a_address, a_mask, a_data, a_corrupt};

  // Next-state for A/D beat counters, queue pointers, occupancy and a_ready.
  always_comb begin
    a_fire   = a_valid && a_ready_q;
    enq      = 1'b0;
    a_beat_d = a_beat_q;
    if (a_fire) begin
      // Opcodes 0..3 carry data and may span several A beats.
      if (!a_opcode[2] && (a_beat_q != beats_m1(a_size))) begin
        a_beat_d = a_beat_q + BeatW'(1);
      end else begin
        a_beat_d = '0;
        enq      = 1'b1;
      end
    end

    d_fire   = d_valid && d_ready;
    d_last   = !head_data || (d_beat_q == beats_m1(head_size));
    deq      = d_fire && d_last;
    d_beat_d = d_beat_q;
    if (d_fire) d_beat_d = d_last ? '0 : d_beat_q + BeatW'(1);

    wr_ptr_d = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (enq && !deq) count_d = count_q + CntW'(1);
    if (!enq && deq) count_d = count_q - CntW'(1);

    // A burst in flight already owns its slot, so it is never stalled mid-way.
    a_ready_d = (a_beat_d != '0) || (count_d < Full);
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      a_beat_q  <= '0;
      d_beat_q  <= '0;
      a_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      a_beat_q  <= a_beat_d;
      d_beat_q  <= d_beat_d;
      a_ready_q <= a_ready_d;
    end
  end

  // Queue storage, written on the last A beat; contents only matter while counted.
  always_ff @(posedge clock) begin
    if (enq) begin
      ent_op_q[wr_ptr_q]   <= a_opcode;
      ent_size_q[wr_ptr_q] <= a_size;
      ent_src_q[wr_ptr_q]  <= a_source;
    end
  end

  // D-channel fields from the queue head, forced to zero while the queue is empty.
  always_comb begin
    d_opcode  = 3'd0;
    d_param   = 2'd0;
    d_size    = '0;
    d_source  = '0;
    d_sink    = 1'b0;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
    d_data    = '0;
    if (d_valid) begin
      d_size    = head_size;
      d_source  = head_src;
      d_denied  = 1'b1;
      d_corrupt = head_data;
      case (head_op)
        3'd2, 3'd3, 3'd4: d_opcode = 3'd1;
        3'd5:             d_opcode = 3'd2;
        default:          d_opcode = 3'd0;
      endcase
    end
  end

`ifdef TL_ERROR_SLAVE_COUNT_EN
  logic [15:0] err_q;

  // Count completed denied responses, saturating.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 16'h0;
    end else if (deq && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 16'h0;
`endif

endmodule
